// File: rtl/byte7seg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : byte7seg_pkg
// Brief   : Shared FSM state encoding and hex segment codes for the
//           byte-to-two-digit 7-segment scanner.
// Revision: 1.0 - initial release
// ============================================================================
package byte7seg_pkg;

  // Scanner FSM state encoding
  typedef enum logic [1:0] {
    ST_OFF = 2'b00,
    ST_GAP = 2'b01,
    ST_DRV = 2'b10
  } scan_state_t;

  // Active-high gfedcba codes; entry n is the glyph for hex digit n
  localparam logic [15:0][6:0] c_seg_tab = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

endpackage : byte7seg_pkg
`default_nettype wire

// File: rtl/hex7seg_decode.sv
`default_nettype none
// ============================================================================
// Module  : hex7seg_decode
// Brief   : Combinational nibble to active-high 7-segment (gfedcba) decoder.
// Revision: 1.0 - initial release
// ============================================================================
module hex7seg_decode
  import byte7seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  // Table lookup of the glyph for the nibble
  assign o_seg = c_seg_tab[i_nib];

endmodule : hex7seg_decode
`default_nettype wire

// File: rtl/byte_hex_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module  : byte_hex_7seg_scan
// Brief   : Shows an 8-bit value as two hex digits on a multiplexed
//           common-anode 7-segment display. Each digit slot is preceded by
//           an all-off gap to suppress ghosting; the byte is resampled once
//           per frame so both digits always come from the same value.
//           Optional macro BYTE7SEG_LZB_EN blanks a leading zero on digit 1.
// Revision: 1.0 - initial release
// ============================================================================
module byte_hex_7seg_scan
  import byte7seg_pkg::*;
#(
  parameter int DIV_W          = 16,
  parameter int GAP_CYC        = 4,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       CLK_I,
  input  logic       RSTN_I,
  input  logic [7:0] S_I,
  input  logic       EN_I,
  output logic [6:0] SEG_O,
  output logic       DP_O,
  output logic [1:0] AN_O
);

  // The gap shares the refresh counter, so GAP_CYC-1 must fit in DIV_W bits
  localparam logic [DIV_W-1:0] c_gap_last = DIV_W'(GAP_CYC - 1);
  localparam logic [DIV_W-1:0] c_cnt_max  = '1;
  localparam logic [6:0]       c_seg_off  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic             c_dp_off   = (SEG_ACTIVE_LOW != 0) ? 1'b1  : 1'b0;
  localparam logic [1:0]       c_an_off   = (AN_ACTIVE_LOW  != 0) ? 2'b11 : 2'b00;

  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             r_dig;
  logic             w_dig_nxt;
  logic [7:0]       r_shadow;
  logic [7:0]       w_shadow_nxt;

  logic [6:0]       r_seg;
  logic [1:0]       r_an;
  logic             r_dp;

  logic [3:0]       w_nib;
  logic [6:0]       w_seg_dec;
  logic             w_lit;
  logic [1:0]       w_an_act;
  logic [6:0]       w_seg_act;
  logic [1:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;

  // Next-state, counter, digit select and frame resampling
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_dig_nxt    = r_dig;
    w_shadow_nxt = r_shadow;
    case (r_state)
      ST_OFF: begin
        if (EN_I) begin
          w_shadow_nxt = S_I;
          w_dig_nxt    = 1'b0;
          w_cnt_nxt    = '0;
          w_state_nxt  = ST_GAP;
        end
      end
      ST_GAP: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_gap_last) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_DRV;
        end
      end
      ST_DRV: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_cnt_max) begin
          w_cnt_nxt   = '0;
          w_dig_nxt   = ~r_dig;
          w_state_nxt = ST_GAP;
          // End of the digit-1 slot closes the frame: take a fresh byte
          if (r_dig) begin
            w_shadow_nxt = S_I;
          end
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
    // Disable overrides every other transition
    if (!EN_I) begin
      w_state_nxt = ST_OFF;
    end
  end

  // Decode the nibble that will be on display in the coming cycle
  assign w_nib = w_dig_nxt ? w_shadow_nxt[7:4] : w_shadow_nxt[3:0];

  hex7seg_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg_dec)
  );

  // Active-high anode/segment image, derived from the next state so the
  // registered outputs line up with the state register cycle for cycle
  always_comb begin
    w_lit = (w_state_nxt == ST_DRV);
`ifdef BYTE7SEG_LZB_EN
    if (w_dig_nxt && (w_shadow_nxt[7:4] == 4'h0)) begin
      w_lit = 1'b0;
    end
`endif
    w_an_act  = 2'b00;
    w_seg_act = 7'h00;
    if (w_lit) begin
      w_an_act  = w_dig_nxt ? 2'b10 : 2'b01;
      w_seg_act = w_seg_dec;
    end
    w_an_nxt  = (AN_ACTIVE_LOW  != 0) ? ~w_an_act  : w_an_act;
    w_seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~w_seg_act : w_seg_act;
  end

  // State, counter, shadow and output registers with synchronous reset
  always_ff @(posedge CLK_I) begin
    if (!RSTN_I) begin
      r_state  <= ST_OFF;
      r_cnt    <= '0;
      r_dig    <= 1'b0;
      r_shadow <= 8'h00;
      r_an     <= c_an_off;
      r_seg    <= c_seg_off;
      r_dp     <= c_dp_off;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dig    <= w_dig_nxt;
      r_shadow <= w_shadow_nxt;
      r_an     <= w_an_nxt;
      r_seg    <= w_seg_nxt;
      r_dp     <= c_dp_off;
    end
  end

  assign AN_O  = r_an;
  assign SEG_O = r_seg;
  assign DP_O  = r_dp;

endmodule : byte_hex_7seg_scan
`default_nettype wire

// File: tb/tb_byte_hex_7seg_scan.sv
`default_nettype none
// ============================================================================
// Module  : tb_byte_hex_7seg_scan
// Brief   : Directed self-checking bench for byte_hex_7seg_scan
//           (DIV_W=4, GAP_CYC=2, active-low outputs).
// Revision: 1.0 - initial release
// ============================================================================
module tb_byte_hex_7seg_scan;

  localparam int c_div_w  = 4;
  localparam int c_gap    = 2;
  localparam int c_slot   = 1 << c_div_w;

  logic       CLK_I = 1'b0;
  logic       RSTN_I;
  logic [7:0] S_I;
  logic       EN_I;
  logic [6:0] SEG_O;
  logic       DP_O;
  logic [1:0] AN_O;

  int n_cmp = 0;
  int n_err = 0;

  // Active-high gfedcba glyphs written out by hand from the decode table
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  byte_hex_7seg_scan #(
    .DIV_W          (c_div_w),
    .GAP_CYC        (c_gap),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .CLK_I  (CLK_I),
    .RSTN_I (RSTN_I),
    .S_I    (S_I),
    .EN_I   (EN_I),
    .SEG_O  (SEG_O),
    .DP_O   (DP_O),
    .AN_O   (AN_O)
  );

  // 100 MHz-style free-running clock
  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // Advance n cycles, checking all outputs after each edge
  task automatic expect_run(input string tag, input logic [1:0] an,
                            input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, " an"},  {6'b0, AN_O}, {6'b0, an});
      chk({tag, " seg"}, {1'b0, SEG_O}, {1'b0, seg});
      chk({tag, " dp"},  {7'b0, DP_O}, 8'h01);
    end
  endtask

  // One full frame showing 'shown'; S_I is moved to 'next_s' mid-frame
  task automatic run_frame(input string tag, input logic [7:0] shown,
                           input logic [7:0] next_s);
    logic [1:0] an1;
    logic [6:0] seg1;
    an1  = 2'b01;
    seg1 = ~glyph[shown[7:4]];
`ifdef BYTE7SEG_LZB_EN
    if (shown[7:4] == 4'h0) begin
      an1  = 2'b11;
      seg1 = 7'h7F;
    end
`endif
    expect_run({tag, " gap0"}, 2'b11, 7'h7F, c_gap);
    expect_run({tag, " d0a"}, 2'b10, ~glyph[shown[3:0]], c_slot / 2);
    S_I = next_s;
    expect_run({tag, " d0b"}, 2'b10, ~glyph[shown[3:0]], c_slot / 2);
    expect_run({tag, " gap1"}, 2'b11, 7'h7F, c_gap);
    expect_run({tag, " d1"}, an1, seg1, c_slot);
  endtask

  initial begin
    // Reset held with the display enabled and an all-ones byte
    RSTN_I = 1'b0;
    EN_I   = 1'b1;
    S_I    = 8'hFF;
    expect_run("reset", 2'b11, 7'h7F, 3);

    // Basic scan of A5, then a mid-frame change to 3C
    S_I    = 8'hA5;
    RSTN_I = 1'b1;
    run_frame("a5_f0", 8'hA5, 8'hA5);
    run_frame("a5_f1", 8'hA5, 8'h3C);
    run_frame("3c_f0", 8'h3C, 8'h3C);

    // Drop enable in the middle of a digit-0 slot
    expect_run("en_gap", 2'b11, 7'h7F, c_gap);
    expect_run("en_d0", 2'b10, 7'h46, 5);
    EN_I = 1'b0;
    expect_run("en_off", 2'b11, 7'h7F, 4);

    // Re-enable with a leading-zero byte: fresh sample, gap, digit 0
    S_I  = 8'h07;
    EN_I = 1'b1;
    run_frame("lz_07", 8'h07, 8'h00);

    // Sweep every byte value, one per frame
    for (int v = 0; v < 256; v++) begin
      run_frame($sformatf("sweep_%02h", v), 8'(v), 8'(v + 1));
    end

    // Reset asserted between edges must not act until the next edge
    expect_run("srst_gap", 2'b11, 7'h7F, c_gap);
    expect_run("srst_d0", 2'b10, 7'h40, 3);
    RSTN_I = 1'b0;
    #3;
    chk("srst_hold an", {6'b0, AN_O}, 8'h02);
    expect_run("srst_edge", 2'b11, 7'h7F, 1);
    S_I    = 8'h5A;
    RSTN_I = 1'b1;
    run_frame("post_rst", 8'h5A, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_byte_hex_7seg_scan
`default_nettype wire
